// File: rtl/wb_result_pipe.sv
// wb_result_pipe: EX/ME/WB destination and result pipeline with forwarding taps and load wait.
// Optional WB_RETIRE_CNT_EN adds a retired-write counter output.
module wb_result_pipe #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pause,
    input  logic          flush,
    input  logic          id_valid,
    input  logic          id_we,
    input  logic [AW-1:0] id_wa,
    input  logic [1:0]    id_cregwd,
    input  logic [DW-1:0] ex_alu,
    input  logic [DW-1:0] ex_pc4,
    input  logic [DW-1:0] ex_imm,
    input  logic          mem_rvalid,
    input  logic [DW-1:0] mem_rdata,
    output logic          stall_mem,
    output logic [1:0]    cregwd_ex,
    output logic          we_ex,
    output logic [AW-1:0] wa_ex,
    output logic [DW-1:0] wd_ex,
    output logic          we_me,
    output logic [AW-1:0] wa_me,
    output logic [DW-1:0] wd_me,
    output logic          we_wb,
    output logic [AW-1:0] wa_wb,
    output logic [DW-1:0] wd_wb
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [31:0]   retire_cnt
`endif
);
    typedef enum logic {ME_RUN, ME_WAIT} me_state_e;
    me_state_e state_q, state_d;
    logic          ex_v_q, ex_v_d, ex_we_q, ex_we_d;
    logic [AW-1:0] ex_wa_q, ex_wa_d;
    logic [1:0]    ex_sel_q, ex_sel_d;
    logic          me_v_q, me_v_d, me_we_q, me_we_d;
    logic [AW-1:0] me_wa_q, me_wa_d;
    logic [1:0]    me_sel_q, me_sel_d;
    logic [DW-1:0] me_wd_q, me_wd_d;
    logic          wb_v_q, wb_v_d, wb_we_q, wb_we_d;
    logic [AW-1:0] wb_wa_q, wb_wa_d;
    logic [DW-1:0] wb_wd_q, wb_wd_d;
    logic          me_load;

    assign me_load   = me_v_q & (me_sel_q == 2'd1);
    // The release cycle (rvalid high) is not a stall: the load retires on that edge.
    assign stall_mem = ((state_q == ME_WAIT) | me_load) & ~mem_rvalid;
    assign state_d   = stall_mem ? ME_WAIT : ME_RUN;

    assign cregwd_ex = ex_sel_q;
    assign we_ex = ex_v_q & ex_we_q & (ex_wa_q != '0);
    assign wa_ex = ex_wa_q;
    assign wd_ex = ex_sel_q == 2'd0 ? ex_alu :
                   ex_sel_q == 2'd2 ? ex_pc4 :
                   ex_sel_q == 2'd3 ? ex_imm : '0;
    assign we_me = me_v_q & me_we_q & (me_wa_q != '0);
    assign wa_me = me_wa_q;
    assign wd_me = me_wd_q;
    assign we_wb = wb_v_q & wb_we_q & (wb_wa_q != '0);
    assign wa_wb = wb_wa_q;
    assign wd_wb = wb_wd_q;

    always_comb begin
        ex_v_d   = stall_mem ? ex_v_q : id_valid & ~pause & ~flush;
        ex_we_d  = stall_mem ? ex_we_q : id_we;
        ex_wa_d  = stall_mem ? ex_wa_q : id_wa;
        ex_sel_d = stall_mem ? ex_sel_q : id_cregwd;
        me_v_d   = stall_mem ? me_v_q : ex_v_q;
        me_we_d  = stall_mem ? me_we_q : ex_we_q;
        me_wa_d  = stall_mem ? me_wa_q : ex_wa_q;
        me_sel_d = stall_mem ? me_sel_q : ex_sel_q;
        me_wd_d  = stall_mem ? me_wd_q : wd_ex;
        wb_v_d   = me_v_q & ~stall_mem;
        wb_we_d  = me_we_q;
        wb_wa_d  = me_wa_q;
        wb_wd_d  = me_load ? mem_rdata : me_wd_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ME_RUN;
            ex_v_q   <= 1'b0;
            ex_we_q  <= 1'b0;
            ex_wa_q  <= '0;
            ex_sel_q <= '0;
            me_v_q   <= 1'b0;
            me_we_q  <= 1'b0;
            me_wa_q  <= '0;
            me_sel_q <= '0;
            me_wd_q  <= '0;
            wb_v_q   <= 1'b0;
            wb_we_q  <= 1'b0;
            wb_wa_q  <= '0;
            wb_wd_q  <= '0;
        end else begin
            state_q  <= state_d;
            ex_v_q   <= ex_v_d;
            ex_we_q  <= ex_we_d;
            ex_wa_q  <= ex_wa_d;
            ex_sel_q <= ex_sel_d;
            me_v_q   <= me_v_d;
            me_we_q  <= me_we_d;
            me_wa_q  <= me_wa_d;
            me_sel_q <= me_sel_d;
            me_wd_q  <= me_wd_d;
            wb_v_q   <= wb_v_d;
            wb_we_q  <= wb_we_d;
            wb_wa_q  <= wb_wa_d;
            wb_wd_q  <= wb_wd_d;
        end
    end

`ifdef WB_RETIRE_CNT_EN
    logic [31:0] retire_cnt_q, retire_cnt_d;
    assign retire_cnt_d = retire_cnt_q + {31'd0, we_wb};
    assign retire_cnt   = retire_cnt_q;
    always_ff @(posedge clk) begin
        if (rst) retire_cnt_q <= '0;
        else     retire_cnt_q <= retire_cnt_d;
    end
`endif
endmodule

// File: tb/tb_wb_result_pipe.sv
// tb_wb_result_pipe: instruction-level model of the result pipeline checked every cycle,
// plus directed scenarios with literal expectations.
module tb_wb_result_pipe;
    logic        clk = 0, rst = 1, pause = 0, flush = 0, id_valid = 0, id_we = 0;
    logic [4:0]  id_wa = 0;
    logic [1:0]  id_cregwd = 0;
    logic [31:0] ex_alu = 0, ex_pc4 = 0, ex_imm = 0, mem_rdata = 0;
    logic        mem_rvalid = 0;
    logic        stall_mem, we_ex, we_me, we_wb;
    logic [1:0]  cregwd_ex;
    logic [4:0]  wa_ex, wa_me, wa_wb;
    logic [31:0] wd_ex, wd_me, wd_wb;
`ifdef WB_RETIRE_CNT_EN
    logic [31:0] retire_cnt;
`endif

    wb_result_pipe #(.DW(32), .AW(5)) dut (
`ifdef WB_RETIRE_CNT_EN
        .retire_cnt(retire_cnt),
`endif
        .clk(clk), .rst(rst), .pause(pause), .flush(flush), .id_valid(id_valid), .id_we(id_we),
        .id_wa(id_wa), .id_cregwd(id_cregwd), .ex_alu(ex_alu), .ex_pc4(ex_pc4), .ex_imm(ex_imm),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .stall_mem(stall_mem), .cregwd_ex(cregwd_ex),
        .we_ex(we_ex), .wa_ex(wa_ex), .wd_ex(wd_ex), .we_me(we_me), .wa_me(wa_me), .wd_me(wd_me),
        .we_wb(we_wb), .wa_wb(wa_wb), .wd_wb(wd_wb));

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;
    bit chk_en = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // One in-flight instruction per stage; a load's data is whatever memory returns when it leaves ME.
    typedef struct packed {
        logic        v;
        logic        we;
        logic [4:0]  wa;
        logic [1:0]  sel;
        logic [31:0] wd;
    } ins_t;
    ins_t m_ex, m_me, m_wb;

    function automatic logic writes(input ins_t s);
        return s.v && s.we && s.wa != 0;
    endfunction

    function automatic logic [31:0] ex_result(input logic [1:0] sel);
        return sel == 0 ? ex_alu : sel == 2 ? ex_pc4 : sel == 3 ? ex_imm : 32'd0;
    endfunction

    wire m_stall = m_me.v && m_me.sel == 2'd1 && !mem_rvalid;

    always @(posedge clk) begin
        if (rst) begin
            m_ex <= '0;
            m_me <= '0;
            m_wb <= '0;
        end else begin
            m_wb <= m_stall ? '0 : '{m_me.v, m_me.we, m_me.wa, m_me.sel,
                                     m_me.sel == 2'd1 ? mem_rdata : m_me.wd};
            if (!m_stall) begin
                m_me <= '{m_ex.v, m_ex.we, m_ex.wa, m_ex.sel, ex_result(m_ex.sel)};
                m_ex <= '{id_valid && !pause && !flush, id_we, id_wa, id_cregwd, 32'd0};
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("we_ex", {31'd0, we_ex}, {31'd0, writes(m_ex)});
            chk("we_me", {31'd0, we_me}, {31'd0, writes(m_me)});
            chk("we_wb", {31'd0, we_wb}, {31'd0, writes(m_wb)});
            chk("stall_mem", {31'd0, stall_mem}, {31'd0, m_stall});
            chk("cregwd_ex", {30'd0, cregwd_ex}, {30'd0, m_ex.sel});
            if (writes(m_ex)) begin
                chk("wa_ex", {27'd0, wa_ex}, {27'd0, m_ex.wa});
                chk("wd_ex", wd_ex, ex_result(m_ex.sel));
            end
            if (writes(m_me)) begin
                chk("wa_me", {27'd0, wa_me}, {27'd0, m_me.wa});
                chk("wd_me", wd_me, m_me.wd);
            end
            if (writes(m_wb)) begin
                chk("wa_wb", {27'd0, wa_wb}, {27'd0, m_wb.wa});
                chk("wd_wb", wd_wb, m_wb.wd);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] wa, input logic [1:0] sel);
        id_valid = 1; id_we = 1; id_wa = wa; id_cregwd = sel;
    endtask

    initial begin
        tick();
        chk_en = 1;
        tick();
        chk("rst we_ex", {31'd0, we_ex}, 0);
        chk("rst we_wb", {31'd0, we_wb}, 0);
        chk("rst stall", {31'd0, stall_mem}, 0);
        chk("rst wa_wb", {27'd0, wa_wb}, 0);
        chk("rst wd_me", wd_me, 0);
        chk("rst wd_wb", wd_wb, 0);
        rst = 0;
        // ALU op reaches WB 3 edges after issue, for exactly one cycle
        issue(5, 0); ex_alu = 32'h1234;
        tick(); chk("alu we_ex", {31'd0, we_ex}, 1); chk("alu wd_ex", wd_ex, 32'h1234);
        id_valid = 0;
        tick(); tick();
        chk("alu we_wb", {31'd0, we_wb}, 1); chk("alu wa_wb", {27'd0, wa_wb}, 5); chk("alu wd_wb", wd_wb, 32'h1234);
        tick(); chk("alu once", {31'd0, we_wb}, 0);
        // writes to $0 never show on any tap
        issue(0, 0);
        tick(); chk("r0 we_ex", {31'd0, we_ex}, 0); id_valid = 0;
        tick(); chk("r0 we_me", {31'd0, we_me}, 0);
        tick(); chk("r0 we_wb", {31'd0, we_wb}, 0);
        // PC+4 and immediate selects
        issue(3, 2); ex_pc4 = 32'h100;
        tick(); chk("pc4 wd_ex", wd_ex, 32'h100);
        issue(4, 3); ex_imm = 32'hABC;
        tick(); chk("imm wd_ex", wd_ex, 32'hABC); chk("pc4 wd_me", wd_me, 32'h100);
        id_valid = 0;
        tick(); tick();
        // load followed by a paused instruction; memory answers on ME entry
        issue(8, 1);
        tick(); issue(9, 0); pause = 1;
        tick(); pause = 0; id_valid = 0; mem_rvalid = 1; mem_rdata = 32'hDEADBEEF; #1;
        chk("pause we_ex", {31'd0, we_ex}, 0); chk("ld we_me", {31'd0, we_me}, 1);
        chk("ld wd_me", wd_me, 0); chk("fast stall", {31'd0, stall_mem}, 0);
        tick(); mem_rvalid = 0;
        chk("ld we_wb", {31'd0, we_wb}, 1); chk("ld wa_wb", {27'd0, wa_wb}, 8); chk("ld wd_wb", wd_wb, 32'hDEADBEEF);
        // slow memory: three wait cycles
        issue(10, 1);
        tick(); issue(11, 0); ex_alu = 32'h55;
        tick(); id_valid = 0; #1;
        for (int i = 0; i < 3; i++) begin
            chk("slow stall", {31'd0, stall_mem}, 1); chk("slow hold wa_ex", {27'd0, wa_ex}, 11);
            chk("slow we_wb", {31'd0, we_wb}, 0);
            tick();
        end
        mem_rvalid = 1; mem_rdata = 32'hCAFEF00D; #1;
        chk("release stall", {31'd0, stall_mem}, 0);
        tick(); mem_rvalid = 0;
        chk("slow wd_wb", wd_wb, 32'hCAFEF00D); chk("slow wa_wb", {27'd0, wa_wb}, 10);
        chk("slow wd_me", wd_me, 32'h55); chk("slow we_ex", {31'd0, we_ex}, 0);
        tick(); chk("slow once", {31'd0, wa_wb}, 11);
        // flush kills only the incoming instruction
        issue(12, 0); ex_alu = 32'h77;
        tick(); issue(13, 0); flush = 1;
        tick(); flush = 0; id_valid = 0;
        chk("flush we_ex", {31'd0, we_ex}, 0); chk("flush wa_me", {27'd0, wa_me}, 12); chk("flush wd_me", wd_me, 32'h77);
        tick(); chk("flush we_wb", {31'd0, we_wb}, 1); chk("flush wa_wb", {27'd0, wa_wb}, 12);
        // reset during a load wait aborts it
        issue(14, 1);
        tick(); id_valid = 0;
        tick(); chk("wait stall", {31'd0, stall_mem}, 1);
        rst = 1;
        tick(); rst = 0;
        chk("rst2 stall", {31'd0, stall_mem}, 0); chk("rst2 we_me", {31'd0, we_me}, 0);
        chk("rst2 wa_me", {27'd0, wa_me}, 0); chk("rst2 we_wb", {31'd0, we_wb}, 0);
        mem_rvalid = 1; mem_rdata = 32'h99;
        tick(); chk("late rvalid 1", {31'd0, we_wb}, 0);
        tick(); chk("late rvalid 2", {31'd0, we_wb}, 0);
        mem_rvalid = 0;
        tick(); tick();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
